latch_seq: RTL and testbench
============================

Name: latch_seq

Overview:
Sequencer for the latch-based TRNG entropy source. It powers up the latch ring, applies a warm-up interval, then repeatedly pulses the latch reset, lets the latch resolve for a programmable interval, and samples one raw bit per cycle of that loop. It packs 32 raw bits into a word and presents it as a one-cycle strobe to the downstream RNG controller, which forwards it to the FIFO.

Parameters:
WARM_CYC, 1024, number of clock cycles LATCH_EN is held before the first latch reset (0 allowed)
CW, 16, width of the warm-up and evaluation counters

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
RUN  in  1  level enable from the AXI control block; 1 = generate words
DIV  in  16  evaluation interval in cycles; 0 is treated as 1
BIT_IN  in  1  raw latch output
LATCH_EN  out  1  latch ring enable
LATCH_RST  out  1  latch reset pulse
DATA_OUT  out  32  last completed word; MSB = oldest bit
DATA_RE  out  1  one-cycle strobe: DATA_OUT holds a new word
WARM  out  1  high while in WARMUP
BITS  out  5  bits collected in the current word

Behaviour:
- Interface: one clock, CLK. RST is asynchronous, active-high. Asserting RST immediately forces all registers to reset values, regardless of the clock.
- Reset values:
  - state = IDLE
  - LATCH_EN = 0, LATCH_RST = 0, DATA_RE = 0, WARM = 0
  - DATA_OUT = 0, BITS = 0
  - internal shift register = 0, counters = 0
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, WARMUP, PRST, EVAL.
- IDLE:
  - LATCH_EN = 0.
  - At the edge where RUN = 1: if WARM_CYC > 0, go to WARMUP and set LATCH_EN = 1 and the warm-up counter to 0; otherwise go straight to PRST.
- WARMUP:
  - LATCH_EN = 1, WARM = 1.
  - The state lasts exactly WARM_CYC cycles, then moves to PRST.
- PRST:
  - Lasts exactly 1 cycle, with LATCH_RST = 1 during that cycle.
  - At its exit edge, latch D = (DIV == 0) ? 1 : DIV into the evaluation counter, then go to EVAL.
  - Changing DIV therefore only takes effect from the next bit.
- EVAL:
  - LATCH_RST = 0. The state lasts D cycles.
  - At the last EVAL edge: the shift register becomes {sr[30:0], BIT_IN}, BITS increments modulo 32, and the state returns to PRST.
- Timing per bit is 1 + D cycles, so one word takes 32 × (1 + D) cycles after warm-up.
- Word completion, at the edge that samples bit 31 (BITS = 31):
  - DATA_OUT <= {sr[30:0], BIT_IN}, DATA_RE <= 1, BITS <= 0.
  - DATA_RE is cleared at the following edge, so it is exactly 1 cycle wide.
  - DATA_OUT holds its value until the next completed word.
- RUN = 0, in any non-IDLE state, at the next edge:
  - Go to IDLE with LATCH_EN = 0, LATCH_RST = 0 and WARM = 0.
  - Clear BITS and the shift register; the partial word is discarded.
  - RUN = 0 has priority: if that same edge would have completed a word, the word is dropped, with no DATA_RE and DATA_OUT unchanged.
- Re-assertion of RUN always repeats the full warm-up.
- BIT_IN is treated as synchronous; metastability handling belongs to the latch wrapper.
- Counter arithmetic is unsigned CW-bit with no wrap. D ≤ 65535 and WARM_CYC < 2^CW are required.

Test Plan:
- Reset check: assert RST for 3 cycles while CLK runs -> all outputs 0 and state IDLE; RUN = 1 held during reset has no effect until RST falls.
- Nominal word (WARM_CYC = 8, DIV = 2, BIT_IN = 1; RUN sampled high at edge 0):
  - LATCH_EN = 1 from edge 0.
  - LATCH_RST high in cycles 8, 11, 14, …
  - Bit k is sampled at edge 11 + 3k.
  - DATA_OUT = 32'hFFFF_FFFF and DATA_RE = 1 for exactly the cycle after edge 104.
  - The next strobe follows edge 200.
- Bit order (DIV = 1): drive BIT_IN from a pattern so the sampled sequence is 1,0,1,0,… starting with 1 -> DATA_OUT = 32'hAAAA_AAAA; a pattern of 28 zeros followed by 1,0,1,1 -> 32'h0000_000B.
- DIV = 0 -> behaves exactly as DIV = 1, i.e. 64 cycles between DATA_RE strobes; changing DIV 2→5 mid-EVAL leaves the current bit at 2 cycles, and the next bit takes 5.
- Abort: drop RUN when BITS = 17 -> no DATA_RE, BITS = 0, LATCH_EN = 0 next edge. Raise RUN again -> WARM high for 8 cycles, and the first word appears 8 + 96 cycles later. Drop RUN exactly on the bit-31 edge -> no strobe, DATA_OUT unchanged.
- Async reset mid-EVAL: pulse RST between clock edges -> LATCH_EN, BITS and DATA_OUT go to 0 before the next edge; after release with RUN = 1, the warm-up restarts.

Source files
------------

// File: rtl/latch_seq_if.sv
// Control, raw-bit and word-output bundle of the latch TRNG sequencer.
// master drives RUN/DIV/BIT_IN; slave (the sequencer) drives the rest.
interface latch_seq_if;
  logic        RUN;
  logic [15:0] DIV;
  logic        BIT_IN;
  logic        LATCH_EN;
  logic        LATCH_RST;
  logic [31:0] DATA_OUT;
  logic        DATA_RE;
  logic        WARM;
  logic [4:0]  BITS;

  modport master (
    output RUN,
    output DIV,
    output BIT_IN,
    input  LATCH_EN,
    input  LATCH_RST,
    input  DATA_OUT,
    input  DATA_RE,
    input  WARM,
    input  BITS
  );

  modport slave (
    input  RUN,
    input  DIV,
    input  BIT_IN,
    output LATCH_EN,
    output LATCH_RST,
    output DATA_OUT,
    output DATA_RE,
    output WARM,
    output BITS
  );
endinterface

// File: rtl/latch_seq.sv
// Latch TRNG sequencer: warm-up, then reset/evaluate/sample loop,
// packing 32 raw bits per word with a one-cycle strobe.
module latch_seq #(
  parameter int unsigned WARM_CYC = 1024,
  parameter int unsigned CW       = 16
) (
  input logic       CLK,
  input logic       RST,
  latch_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    PRST,
    EVAL
  } state_t;

  localparam logic [CW-1:0] WLAST = CW'(WARM_CYC - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t        state, state_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic [CW-1:0] ecnt, ecnt_n;
  logic [CW-1:0] div_d;
  logic [31:0]   sr, sr_n;
  logic [31:0]   shifted;
  logic [31:0]   dout_q, dout_n;
  logic [4:0]    bits_q, bits_n;
  logic          re_q, re_n;
  logic          en_q, lrst_q, warm_q;

  assign div_d   = (bus.DIV == '0) ? ONE : CW'(bus.DIV);
  assign shifted = {sr[30:0], bus.BIT_IN};

  assign bus.LATCH_EN  = en_q;
  assign bus.LATCH_RST = lrst_q;
  assign bus.DATA_OUT  = dout_q;
  assign bus.DATA_RE   = re_q;
  assign bus.WARM      = warm_q;
  assign bus.BITS      = bits_q;

  // Next state and datapath; a dropped RUN overrides everything else.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    ecnt_n  = ecnt;
    sr_n    = sr;
    bits_n  = bits_q;
    dout_n  = dout_q;
    re_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.RUN) begin
          if (WARM_CYC > 0) begin
            state_n = WARMUP;
            wcnt_n  = '0;
          end else begin
            state_n = PRST;
          end
        end
      end
      WARMUP: begin
        if (wcnt == WLAST) begin
          state_n = PRST;
        end else begin
          wcnt_n = wcnt + ONE;
        end
      end
      PRST: begin
        ecnt_n  = div_d;
        state_n = EVAL;
      end
      EVAL: begin
        if (ecnt == ONE) begin
          sr_n    = shifted;
          bits_n  = bits_q + 5'd1;
          state_n = PRST;
          if (bits_q == 5'd31) begin
            dout_n = shifted;
            re_n   = 1'b1;
          end
        end else begin
          ecnt_n = ecnt - ONE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !bus.RUN) begin
      state_n = IDLE;
      sr_n    = '0;
      bits_n  = '0;
      dout_n  = dout_q;
      re_n    = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      wcnt   <= '0;
      ecnt   <= '0;
      sr     <= '0;
      bits_q <= '0;
      dout_q <= '0;
      re_q   <= 1'b0;
      en_q   <= 1'b0;
      lrst_q <= 1'b0;
      warm_q <= 1'b0;
    end else begin
      state  <= state_n;
      wcnt   <= wcnt_n;
      ecnt   <= ecnt_n;
      sr     <= sr_n;
      bits_q <= bits_n;
      dout_q <= dout_n;
      re_q   <= re_n;
      en_q   <= (state_n != IDLE);
      lrst_q <= (state_n == PRST);
      warm_q <= (state_n == WARMUP);
    end
  end

endmodule

// File: tb/tb_latch_seq.sv
// Directed bench for latch_seq with an 8-cycle warm-up.
// Edge e counts from the edge that first samples RUN high.
module tb_latch_seq;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  latch_seq_if u_if ();

  latch_seq #(
    .WARM_CYC(8),
    .CW(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(u_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    u_if.RUN = 1'b1;
    u_if.DIV = 16'd2;
    u_if.BIT_IN = 1'b0;
    repeat (3) tick();
    checks++;
    if (u_if.LATCH_EN !== 1'b0) begin
      errors++; $display("FAIL rst_en got %b exp 0", u_if.LATCH_EN);
    end
    checks++;
    if (u_if.LATCH_RST !== 1'b0) begin
      errors++; $display("FAIL rst_lrst got %b exp 0", u_if.LATCH_RST);
    end
    checks++;
    if (u_if.DATA_RE !== 1'b0) begin
      errors++; $display("FAIL rst_re got %b exp 0", u_if.DATA_RE);
    end
    checks++;
    if (u_if.WARM !== 1'b0) begin
      errors++; $display("FAIL rst_warm got %b exp 0", u_if.WARM);
    end
    checks++;
    if (u_if.DATA_OUT !== 32'h0) begin
      errors++; $display("FAIL rst_dout got %h exp 0", u_if.DATA_OUT);
    end
    checks++;
    if (u_if.BITS !== 5'd0) begin
      errors++; $display("FAIL rst_bits got %0d exp 0", u_if.BITS);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (u_if.WARM !== 1'b1 || u_if.LATCH_EN !== 1'b1) begin
      errors++;
      $display("FAIL rst_release got warm=%b en=%b exp 1 1",
               u_if.WARM, u_if.LATCH_EN);
    end
    u_if.RUN = 1'b0;
    tick();
    checks++;
    if (u_if.LATCH_EN !== 1'b0 || u_if.WARM !== 1'b0) begin
      errors++;
      $display("FAIL rst_stop got en=%b warm=%b exp 0 0",
               u_if.LATCH_EN, u_if.WARM);
    end
  endtask

  task automatic test_nominal;
    logic xr, xre, xw;
    u_if.DIV = 16'd2;
    u_if.BIT_IN = 1'b1;
    u_if.RUN = 1'b1;
    tick();
    checks++;
    if (u_if.LATCH_EN !== 1'b1 || u_if.WARM !== 1'b1) begin
      errors++;
      $display("FAIL nom_e0 got en=%b warm=%b exp 1 1",
               u_if.LATCH_EN, u_if.WARM);
    end
    for (int e = 1; e <= 201; e++) begin
      tick();
      xr  = (e >= 8) && ((e - 8) % 3 == 0);
      xre = (e == 104) || (e == 200);
      xw  = (e < 8);
      checks++;
      if (u_if.LATCH_RST !== xr) begin
        errors++;
        $display("FAIL nom_lrst e=%0d got %b exp %b", e, u_if.LATCH_RST, xr);
      end
      checks++;
      if (u_if.DATA_RE !== xre) begin
        errors++;
        $display("FAIL nom_re e=%0d got %b exp %b", e, u_if.DATA_RE, xre);
      end
      checks++;
      if (u_if.WARM !== xw) begin
        errors++;
        $display("FAIL nom_warm e=%0d got %b exp %b", e, u_if.WARM, xw);
      end
      checks++;
      if (u_if.LATCH_EN !== 1'b1) begin
        errors++;
        $display("FAIL nom_en e=%0d got %b exp 1", e, u_if.LATCH_EN);
      end
      if (e == 11) begin
        checks++;
        if (u_if.BITS !== 5'd1) begin
          errors++; $display("FAIL nom_bits11 got %0d exp 1", u_if.BITS);
        end
      end
      if (e == 104) begin
        checks++;
        if (u_if.DATA_OUT !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL nom_dout got %h exp ffffffff", u_if.DATA_OUT);
        end
        checks++;
        if (u_if.BITS !== 5'd0) begin
          errors++; $display("FAIL nom_bits104 got %0d exp 0", u_if.BITS);
        end
      end
    end
    u_if.RUN = 1'b0;
    tick();
    checks++;
    if (u_if.LATCH_EN !== 1'b0 || u_if.BITS !== 5'd0 ||
        u_if.LATCH_RST !== 1'b0) begin
      errors++;
      $display("FAIL nom_stop got en=%b bits=%0d lrst=%b exp 0 0 0",
               u_if.LATCH_EN, u_if.BITS, u_if.LATCH_RST);
    end
  endtask

  task automatic test_bit_order;
    logic [31:0] pat;
    logic        xr;
    int          k;
    u_if.DIV = 16'd1;
    u_if.BIT_IN = 1'b0;
    u_if.RUN = 1'b1;
    tick();
    for (int e = 1; e <= 137; e++) begin
      if (e >= 10) begin
        k   = (e - 10) / 2;
        pat = (k < 32) ? 32'hAAAA_AAAA : 32'h0000_000B;
        u_if.BIT_IN = pat[31 - (k % 32)];
      end else begin
        u_if.BIT_IN = 1'b0;
      end
      tick();
      xr = (e >= 8) && (e % 2 == 0);
      checks++;
      if (u_if.LATCH_RST !== xr) begin
        errors++;
        $display("FAIL ord_lrst e=%0d got %b exp %b", e, u_if.LATCH_RST, xr);
      end
      if (e == 72) begin
        checks++;
        if (u_if.DATA_RE !== 1'b1 || u_if.DATA_OUT !== 32'hAAAA_AAAA) begin
          errors++;
          $display("FAIL ord_w0 got re=%b dout=%h exp 1 aaaaaaaa",
                   u_if.DATA_RE, u_if.DATA_OUT);
        end
      end
      if (e == 73) begin
        checks++;
        if (u_if.DATA_RE !== 1'b0) begin
          errors++; $display("FAIL ord_re73 got %b exp 0", u_if.DATA_RE);
        end
      end
      if (e == 100) begin
        checks++;
        if (u_if.DATA_OUT !== 32'hAAAA_AAAA) begin
          errors++;
          $display("FAIL ord_hold got %h exp aaaaaaaa", u_if.DATA_OUT);
        end
      end
      if (e == 136) begin
        checks++;
        if (u_if.DATA_RE !== 1'b1 || u_if.DATA_OUT !== 32'h0000_000B) begin
          errors++;
          $display("FAIL ord_w1 got re=%b dout=%h exp 1 0000000b",
                   u_if.DATA_RE, u_if.DATA_OUT);
        end
      end
    end
    u_if.RUN = 1'b0;
    tick();
  endtask

  task automatic test_div0;
    int n;
    n = 0;
    u_if.DIV = 16'd0;
    u_if.BIT_IN = 1'b0;
    u_if.RUN = 1'b1;
    tick();
    for (int e = 1; e <= 137; e++) begin
      tick();
      if (u_if.DATA_RE === 1'b1) n++;
      if (e == 72) begin
        checks++;
        if (u_if.DATA_RE !== 1'b1 || u_if.DATA_OUT !== 32'h0) begin
          errors++;
          $display("FAIL div0_w0 got re=%b dout=%h exp 1 00000000",
                   u_if.DATA_RE, u_if.DATA_OUT);
        end
      end
      if (e == 136) begin
        checks++;
        if (u_if.DATA_RE !== 1'b1) begin
          errors++; $display("FAIL div0_w1 got %b exp 1", u_if.DATA_RE);
        end
      end
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL div0_count got %0d exp 2", n);
    end
    u_if.RUN = 1'b0;
    tick();
  endtask

  task automatic test_div_change;
    logic xr;
    u_if.DIV = 16'd2;
    u_if.BIT_IN = 1'b1;
    u_if.RUN = 1'b1;
    tick();
    for (int e = 1; e <= 18; e++) begin
      if (e == 10) u_if.DIV = 16'd5;
      tick();
      xr = (e == 8) || (e == 11) || (e == 17);
      checks++;
      if (u_if.LATCH_RST !== xr) begin
        errors++;
        $display("FAIL dch_lrst e=%0d got %b exp %b", e, u_if.LATCH_RST, xr);
      end
      if (e == 10 || e == 11 || e == 16 || e == 17) begin
        checks++;
        if (u_if.BITS !== ((e == 10) ? 5'd0 : (e == 17) ? 5'd2 : 5'd1)) begin
          errors++;
          $display("FAIL dch_bits e=%0d got %0d", e, u_if.BITS);
        end
      end
    end
    u_if.RUN = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    int n;
    n = 0;
    u_if.DIV = 16'd2;
    u_if.BIT_IN = 1'b1;
    u_if.RUN = 1'b1;
    tick();
    repeat (59) tick();
    checks++;
    if (u_if.BITS !== 5'd17) begin
      errors++; $display("FAIL ab_bits17 got %0d exp 17", u_if.BITS);
    end
    u_if.RUN = 1'b0;
    tick();
    checks++;
    if (u_if.DATA_RE !== 1'b0 || u_if.BITS !== 5'd0 ||
        u_if.LATCH_EN !== 1'b0 || u_if.WARM !== 1'b0 ||
        u_if.LATCH_RST !== 1'b0 || u_if.DATA_OUT !== 32'h0) begin
      errors++;
      $display("FAIL ab_drop got re=%b bits=%0d en=%b warm=%b dout=%h",
               u_if.DATA_RE, u_if.BITS, u_if.LATCH_EN, u_if.WARM,
               u_if.DATA_OUT);
    end
    u_if.RUN = 1'b1;
    tick();
    checks++;
    if (u_if.WARM !== 1'b1) begin
      errors++; $display("FAIL ab_warm0 got %b exp 1", u_if.WARM);
    end
    for (int e = 1; e <= 200; e++) begin
      if (e == 105) u_if.BIT_IN = 1'b0;
      if (e == 200) u_if.RUN = 1'b0;
      tick();
      if (u_if.DATA_RE === 1'b1) n++;
      checks++;
      if (u_if.WARM !== (e < 8)) begin
        errors++;
        $display("FAIL ab_warm e=%0d got %b exp %b", e, u_if.WARM, e < 8);
      end
      if (e == 104) begin
        checks++;
        if (u_if.DATA_RE !== 1'b1 || u_if.DATA_OUT !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL ab_word got re=%b dout=%h exp 1 ffffffff",
                   u_if.DATA_RE, u_if.DATA_OUT);
        end
      end
      if (e == 199) begin
        checks++;
        if (u_if.BITS !== 5'd31) begin
          errors++; $display("FAIL ab_bits31 got %0d exp 31", u_if.BITS);
        end
      end
      if (e == 200) begin
        checks++;
        if (u_if.DATA_RE !== 1'b0 || u_if.DATA_OUT !== 32'hFFFF_FFFF ||
            u_if.BITS !== 5'd0 || u_if.LATCH_EN !== 1'b0) begin
          errors++;
          $display("FAIL ab_last got re=%b dout=%h bits=%0d en=%b",
                   u_if.DATA_RE, u_if.DATA_OUT, u_if.BITS, u_if.LATCH_EN);
        end
      end
    end
    tick();
    checks++;
    if (u_if.DATA_RE !== 1'b0 || n != 1) begin
      errors++;
      $display("FAIL ab_strobes got re=%b n=%0d exp 0 1", u_if.DATA_RE, n);
    end
  endtask

  task automatic test_async_reset;
    u_if.DIV = 16'd2;
    u_if.BIT_IN = 1'b1;
    u_if.RUN = 1'b1;
    tick();
    repeat (40) tick();
    checks++;
    if (u_if.BITS !== 5'd10 || u_if.LATCH_EN !== 1'b1 ||
        u_if.DATA_OUT !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL ar_pre got bits=%0d en=%b dout=%h exp 10 1 ffffffff",
               u_if.BITS, u_if.LATCH_EN, u_if.DATA_OUT);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (u_if.LATCH_EN !== 1'b0 || u_if.BITS !== 5'd0 ||
        u_if.DATA_OUT !== 32'h0) begin
      errors++;
      $display("FAIL ar_async got en=%b bits=%0d dout=%h exp 0 0 0",
               u_if.LATCH_EN, u_if.BITS, u_if.DATA_OUT);
    end
    #1;
    RST = 1'b0;
    tick();
    checks++;
    if (u_if.WARM !== 1'b1 || u_if.LATCH_EN !== 1'b1) begin
      errors++;
      $display("FAIL ar_restart got warm=%b en=%b exp 1 1",
               u_if.WARM, u_if.LATCH_EN);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) begin
        checks++;
        if (u_if.WARM !== 1'b1) begin
          errors++; $display("FAIL ar_warm7 got %b exp 1", u_if.WARM);
        end
      end
      if (e == 8) begin
        checks++;
        if (u_if.WARM !== 1'b0 || u_if.LATCH_RST !== 1'b1) begin
          errors++;
          $display("FAIL ar_prst got warm=%b lrst=%b exp 0 1",
                   u_if.WARM, u_if.LATCH_RST);
        end
      end
    end
    u_if.RUN = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    u_if.RUN = 1'b0;
    u_if.DIV = 16'd0;
    u_if.BIT_IN = 1'b0;
    test_reset();
    test_nominal();
    test_bit_order();
    test_div0();
    test_div_change();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
